// File: rtl/ofifo_psum_drain.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// ofifo_psum_drain
//
// Purpose:
//   Consumer-side controller for the core's output FIFO (OFIFO). Once a
//   transfer is launched it pops partial-sum vectors from the OFIFO and writes
//   them to the psum SRAM at consecutive addresses. Each transfer either
//   overwrites the SRAM contents (one vector per cycle) or accumulates into
//   them (read, then add and write: one vector per two cycles). An optional
//   per-lane ReLU is applied to the value being written.
//
// Parameters:
//   col      - number of psum lanes per vector
//   psum_bw  - bits per lane, signed two's complement
//   addr_bw  - psum SRAM address width
//
// Ports:
//   clk         in   clock
//   reset       in   synchronous, active-high reset
//   start       in   one-cycle launch pulse, honoured only while idle
//   len         in   number of vectors to drain (sampled on start)
//   base_addr   in   first SRAM address (sampled on start)
//   acc_en      in   1 = read-add-write, 0 = overwrite (sampled on start)
//   relu_en     in   1 = clamp negative lanes to zero (sampled on start)
//   o_valid     in   OFIFO non-empty
//   ofifo_dout  in   OFIFO head vector, show-ahead; lane i = [i*psum_bw +: psum_bw]
//   rd_ofifo    out  pop strobe; head consumed on the edge where it is high
//   mem_cen     out  SRAM chip enable, active-low
//   mem_wen     out  SRAM write enable, active-low (1 = read)
//   mem_addr    out  SRAM address
//   mem_din     out  SRAM write data
//   mem_dout    in   SRAM read data, valid the cycle after a read
//   busy        out  high while vectors are being moved
//   done        out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module ofifo_psum_drain #(
    parameter int col     = 4,
    parameter int psum_bw = 16,
    parameter int addr_bw = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [addr_bw:0]         len,
    input  logic [addr_bw-1:0]       base_addr,
    input  logic                     acc_en,
    input  logic                     relu_en,
    input  logic                     o_valid,
    input  logic [col*psum_bw-1:0]   ofifo_dout,
    output logic                     rd_ofifo,
    output logic                     mem_cen,
    output logic                     mem_wen,
    output logic [addr_bw-1:0]       mem_addr,
    output logic [col*psum_bw-1:0]   mem_din,
    input  logic [col*psum_bw-1:0]   mem_dout,
    output logic                     busy,
    output logic                     done
);

    localparam int DW = col * psum_bw;

    localparam logic [addr_bw-1:0] ADDR_ONE = {{(addr_bw-1){1'b0}}, 1'b1};
    localparam logic [addr_bw:0]   CNT_ONE  = {{addr_bw{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ADD   = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // State and latched transfer configuration
    // -------------------------------------------------------------------------
    state_t             r_state;
    logic [addr_bw-1:0] r_addr;     // next SRAM address to touch
    logic [addr_bw:0]   r_cnt;      // vectors completed in this transfer
    logic [addr_bw:0]   r_len;      // vectors requested
    logic               r_acc;
    logic               r_relu;
    logic [DW-1:0]      r_hold;     // popped head waiting for its SRAM read

    logic [addr_bw:0]   w_cnt_next;
    logic               w_last;
    logic [DW-1:0]      w_sum;
    logic [DW-1:0]      w_sum_f;
    logic [DW-1:0]      w_head_f;

    // Lane-wise ReLU: a lane with its sign bit set is replaced by zero.
    function automatic logic [DW-1:0] relu_vec(input logic [DW-1:0] v,
                                               input logic          en);
        logic [DW-1:0] r;
        r = v;
        if (en) begin
            for (int i = 0; i < col; i++) begin
                if (v[i*psum_bw + psum_bw - 1]) begin
                    r[i*psum_bw +: psum_bw] = '0;
                end
            end
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    // Each lane sum is kept at psum_bw bits so overflow wraps rather than
    // saturating; ReLU is applied to the wrapped result.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < col; i++) begin
            w_sum[i*psum_bw +: psum_bw] = mem_dout[i*psum_bw +: psum_bw]
                                        + r_hold[i*psum_bw +: psum_bw];
        end
    end

    assign w_sum_f    = relu_vec(w_sum, r_relu);
    assign w_head_f   = relu_vec(ofifo_dout, r_relu);
    assign w_cnt_next = r_cnt + CNT_ONE;
    assign w_last     = (w_cnt_next == r_len);

    // -------------------------------------------------------------------------
    // Memory and pop strobes, decoded from state, registers and o_valid
    // -------------------------------------------------------------------------
    // NOTE: every output gets a default before the case so no path through
    // this block leaves a signal unassigned, which would infer a latch.
    always_comb begin
        rd_ofifo = 1'b0;
        mem_cen  = 1'b1;
        mem_wen  = 1'b1;
        mem_addr = '0;
        mem_din  = '0;
        unique case (r_state)
            S_FETCH: begin
                // Nothing moves while the FIFO is empty, so an empty FIFO is
                // never popped and no SRAM access is issued.
                if (o_valid) begin
                    rd_ofifo = 1'b1;
                    mem_cen  = 1'b0;
                    mem_addr = r_addr;
                    if (!r_acc) begin
                        mem_wen = 1'b0;
                        mem_din = w_head_f;
                    end
                end
            end
            S_ADD: begin
                // The read issued in FETCH returns now; write the sum back to
                // the same address. No pop here regardless of o_valid.
                mem_cen  = 1'b0;
                mem_wen  = 1'b0;
                mem_addr = r_addr;
                mem_din  = w_sum_f;
            end
            default: begin
            end
        endcase
    end

    assign busy = (r_state == S_FETCH) || (r_state == S_ADD);
    assign done = (r_state == S_FIN);

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    // NOTE: all state here uses non-blocking assignments so every register
    // updates from pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_acc   <= 1'b0;
            r_relu  <= 1'b0;
            r_hold  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len   <= len;
                        r_acc   <= acc_en;
                        r_relu  <= relu_en;
                        r_addr  <= base_addr;
                        r_cnt   <= '0;
                        // A zero-length transfer completes without touching
                        // the FIFO or the SRAM.
                        r_state <= (len == '0) ? S_FIN : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (o_valid) begin
                        if (r_acc) begin
                            r_hold  <= ofifo_dout;
                            r_state <= S_ADD;
                        end else begin
                            // Address wraps naturally at addr_bw bits.
                            r_addr  <= r_addr + ADDR_ONE;
                            r_cnt   <= w_cnt_next;
                            r_state <= w_last ? S_FIN : S_FETCH;
                        end
                    end
                end
                S_ADD: begin
                    r_addr  <= r_addr + ADDR_ONE;
                    r_cnt   <= w_cnt_next;
                    r_state <= w_last ? S_FIN : S_FETCH;
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ofifo_psum_drain.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_ofifo_psum_drain
//
// Drives ofifo_psum_drain against a behavioural OFIFO and psum SRAM. Each
// cycle the outputs are sampled on the falling edge and logged; the FIFO pop,
// SRAM write and SRAM read data are applied just after the rising edge.
// Scenario tasks compare the log against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_ofifo_psum_drain;

    localparam int COL = 4;
    localparam int PBW = 16;
    localparam int ABW = 11;
    localparam int DW  = COL * PBW;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [ABW:0]   len;
    logic [ABW-1:0] base_addr;
    logic           acc_en;
    logic           relu_en;
    logic           o_valid;
    logic [DW-1:0]  ofifo_dout;
    logic           rd_ofifo;
    logic           mem_cen;
    logic           mem_wen;
    logic [ABW-1:0] mem_addr;
    logic [DW-1:0]  mem_din;
    logic [DW-1:0]  mem_dout;
    logic           busy;
    logic           done;

    always #5 clk = ~clk;

    ofifo_psum_drain #(.col(COL), .psum_bw(PBW), .addr_bw(ABW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .base_addr  (base_addr),
        .acc_en     (acc_en),
        .relu_en    (relu_en),
        .o_valid    (o_valid),
        .ofifo_dout (ofifo_dout),
        .rd_ofifo   (rd_ofifo),
        .mem_cen    (mem_cen),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .busy       (busy),
        .done       (done)
    );

    // Behavioural SRAM and FIFO
    logic [DW-1:0] sram [0:2047];
    logic [DW-1:0] fifo [0:63];
    int            fifo_wr;
    int            fifo_rd;
    logic          vgate;
    logic          vgate_q[$];

    int n_checks;
    int n_errors;

    // Per-transfer log
    int             cyc;
    int             n_pop;
    int             n_bad_pop;
    int             n_cen;
    int             busy_cnt;
    int             done_cnt;
    int             done_cyc;
    int             wr_cyc[$];
    logic [ABW-1:0] wr_addr[$];
    logic [DW-1:0]  wr_data[$];
    int             rd_cyc[$];
    logic [ABW-1:0] rd_addr[$];

    function automatic logic [DW-1:0] pack(input int l0, input int l1,
                                           input int l2, input int l3);
        logic [DW-1:0] v;
        v[15:0]  = l0[15:0];
        v[31:16] = l1[15:0];
        v[47:32] = l2[15:0];
        v[63:48] = l3[15:0];
        return v;
    endfunction

    task automatic drive_fifo();
        o_valid    = vgate && (fifo_rd < fifo_wr);
        ofifo_dout = fifo[fifo_rd & 63];
    endtask

    task automatic push(input logic [DW-1:0] v);
        fifo[fifo_wr & 63] = v;
        fifo_wr++;
        drive_fifo();
    endtask

    task automatic clear_log();
        cyc = 0; n_pop = 0; n_bad_pop = 0; n_cen = 0;
        busy_cnt = 0; done_cnt = 0; done_cyc = -1;
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
        rd_cyc.delete(); rd_addr.delete();
    endtask

    // One clock cycle: sample mid-cycle, then apply the edge's effects.
    task automatic cycle();
        logic           p_pop, p_wr, p_rd;
        logic [ABW-1:0] p_addr;
        logic [DW-1:0]  p_din;
        @(negedge clk);
        p_pop  = rd_ofifo;
        p_wr   = !mem_cen && !mem_wen;
        p_rd   = !mem_cen && mem_wen;
        p_addr = mem_addr;
        p_din  = mem_din;
        if (rd_ofifo && !o_valid) n_bad_pop++;
        if (!mem_cen) n_cen++;
        if (busy) busy_cnt++;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (p_pop) n_pop++;
        if (p_wr) begin wr_cyc.push_back(cyc); wr_addr.push_back(p_addr); wr_data.push_back(p_din); end
        if (p_rd) begin rd_cyc.push_back(cyc); rd_addr.push_back(p_addr); end
        @(posedge clk);
        #1;
        if (p_pop) fifo_rd++;
        if (p_wr) sram[p_addr] = p_din;
        if (p_rd) mem_dout = sram[p_addr];
        if (vgate_q.size() > 0) vgate = vgate_q.pop_front();
        else vgate = 1'b1;
        drive_fifo();
        cyc++;
    endtask

    // Pulse start for one cycle, then scramble the config inputs so any
    // use of unlatched values shows up.
    task automatic start_xfer(input int l, input int b, input logic a, input logic r);
        len       = l[ABW:0];
        base_addr = b[ABW-1:0];
        acc_en    = a;
        relu_en   = r;
        start     = 1'b1;
        cycle();
        start     = 1'b0;
        len       = 12'd4095;
        base_addr = 11'd1234;
        acc_en    = ~a;
        relu_en   = ~r;
    endtask

    task automatic run_until_done(input string name);
        while (done_cnt == 0 && cyc < 60) cycle();
        if (done_cnt == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: done not seen within 60 cycles", name);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        clear_log();
        reset = 1'b1; start = 1'b1; len = 12'd3; base_addr = 11'd9; acc_en = 1'b1;
        push(pack(7, 7, 7, 7));
        repeat (3) cycle();
        @(negedge clk);
        n_checks++;
        if ({rd_ofifo, mem_cen, mem_wen, mem_addr, mem_din, busy, done} !==
            {1'b0, 1'b1, 1'b1, 11'd0, 64'd0, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_outputs: got rd=%b cen=%b wen=%b addr=%0d din=%h busy=%b done=%b expected 0 1 1 0 0 0 0",
                     rd_ofifo, mem_cen, mem_wen, mem_addr, mem_din, busy, done);
        end
        @(posedge clk);
        #1;
        start = 1'b0; reset = 1'b0; acc_en = 1'b0;
        repeat (3) cycle();
        n_checks++;
        if (n_pop != 0 || n_cen != 0 || busy_cnt != 0 || done_cnt != 0) begin
            n_errors++;
            $display("FAIL reset_quiet: got pops=%0d cen_cycles=%0d busy=%0d done=%0d expected all 0",
                     n_pop, n_cen, busy_cnt, done_cnt);
        end
        fifo_rd = fifo_wr;
        drive_fifo();
    endtask

    task automatic test_overwrite();
        logic [ABW-1:0] ea[3];
        logic [DW-1:0]  ed[3];
        int             ec[3];
        ea = '{11'd5, 11'd6, 11'd7};
        ed = '{pack(1, 2, 3, 4), pack(-1, 0, 7, 8), pack(9, 9, 9, 9)};
        ec = '{1, 2, 3};
        for (int i = 0; i < 3; i++) push(ed[i]);
        clear_log();
        start_xfer(3, 5, 1'b0, 1'b0);
        run_until_done("ovr");
        cycle();
        n_checks++;
        if (wr_addr.size() != 3) begin
            n_errors++;
            $display("FAIL ovr_write_count: got %0d expected 3", wr_addr.size());
        end
        for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
            n_checks++;
            if (wr_addr[i] !== ea[i] || wr_data[i] !== ed[i] || wr_cyc[i] != ec[i]) begin
                n_errors++;
                $display("FAIL ovr_write%0d: got addr=%0d data=%h cyc=%0d expected addr=%0d data=%h cyc=%0d",
                         i, wr_addr[i], wr_data[i], wr_cyc[i], ea[i], ed[i], ec[i]);
            end
        end
        n_checks++;
        if (n_pop != 3 || done_cyc != 4 || done_cnt != 1 || busy_cnt != 3 || rd_addr.size() != 0) begin
            n_errors++;
            $display("FAIL ovr_ctrl: got pops=%0d done_cyc=%0d dones=%0d busy=%0d reads=%0d expected 3 4 1 3 0",
                     n_pop, done_cyc, done_cnt, busy_cnt, rd_addr.size());
        end
    endtask

    task automatic test_accumulate();
        sram[0] = pack(10, -20, 30, -40);
        push(pack(1, 1, 1, 1));
        clear_log();
        start_xfer(1, 0, 1'b1, 1'b0);
        run_until_done("acc");
        n_checks++;
        if (rd_addr.size() != 1 || rd_addr[0] !== 11'd0 || rd_cyc[0] != 1) begin
            n_errors++;
            $display("FAIL acc_read: got n=%0d addr=%0d cyc=%0d expected 1 0 1",
                     rd_addr.size(), rd_addr[0], rd_cyc[0]);
        end
        n_checks++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 11'd0 || wr_cyc[0] != 2 ||
            wr_data[0] !== pack(11, -19, 31, -39)) begin
            n_errors++;
            $display("FAIL acc_write: got n=%0d addr=%0d cyc=%0d data=%h expected 1 0 2 %h",
                     wr_addr.size(), wr_addr[0], wr_cyc[0], wr_data[0], pack(11, -19, 31, -39));
        end
        n_checks++;
        if (n_pop != 1 || busy_cnt != 2 || done_cyc != 3) begin
            n_errors++;
            $display("FAIL acc_ctrl: got pops=%0d busy=%0d done_cyc=%0d expected 1 2 3",
                     n_pop, busy_cnt, done_cyc);
        end
    endtask

    task automatic test_relu_wrap();
        sram[10] = pack(32767, -5, 3, 0);
        sram[11] = pack(5, -5, 100, 0);
        push(pack(1, 2, -10, -1));
        push(pack(1, 2, -50, 0));
        clear_log();
        start_xfer(2, 10, 1'b1, 1'b1);
        run_until_done("relu");
        n_checks++;
        if (wr_addr.size() != 2 || wr_addr[0] !== 11'd10 || wr_data[0] !== 64'd0 || wr_cyc[0] != 2) begin
            n_errors++;
            $display("FAIL relu_wrap_write: got n=%0d addr=%0d data=%h cyc=%0d expected 2 10 0 2",
                     wr_addr.size(), wr_addr[0], wr_data[0], wr_cyc[0]);
        end
        n_checks++;
        if (wr_addr[1] !== 11'd11 || wr_data[1] !== pack(6, 0, 50, 0) || wr_cyc[1] != 4) begin
            n_errors++;
            $display("FAIL relu_pos_write: got addr=%0d data=%h cyc=%0d expected 11 %h 4",
                     wr_addr[1], wr_data[1], wr_cyc[1], pack(6, 0, 50, 0));
        end
        n_checks++;
        if (rd_addr.size() != 2 || rd_addr[1] !== 11'd11 || rd_cyc[1] != 3 || done_cyc != 5 || n_pop != 2) begin
            n_errors++;
            $display("FAIL relu_ctrl: got reads=%0d addr1=%0d cyc1=%0d done_cyc=%0d pops=%0d expected 2 11 3 5 2",
                     rd_addr.size(), rd_addr[1], rd_cyc[1], done_cyc, n_pop);
        end
        // ReLU on the overwrite path
        push(pack(-1, 5, -32768, 32767));
        clear_log();
        start_xfer(1, 40, 1'b0, 1'b1);
        run_until_done("relu_ovr");
        n_checks++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 11'd40 || wr_data[0] !== pack(0, 5, 0, 32767)) begin
            n_errors++;
            $display("FAIL relu_ovr_write: got n=%0d addr=%0d data=%h expected 1 40 %h",
                     wr_addr.size(), wr_addr[0], wr_data[0], pack(0, 5, 0, 32767));
        end
    endtask

    task automatic test_stall();
        logic [ABW-1:0] ea[4];
        logic [DW-1:0]  ed[4];
        int             ec[4];
        ea = '{11'd200, 11'd201, 11'd202, 11'd203};
        ed = '{pack(21, 22, 23, 24), pack(-31, 32, -33, 34), pack(41, 0, 0, 44), pack(0, -1, 2, -3)};
        ec = '{1, 4, 5, 7};
        for (int i = 0; i < 4; i++) push(ed[i]);
        vgate_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        clear_log();
        start_xfer(4, 200, 1'b0, 1'b0);
        run_until_done("stall");
        n_checks++;
        if (wr_addr.size() != 4) begin
            n_errors++;
            $display("FAIL stall_write_count: got %0d expected 4", wr_addr.size());
        end
        for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
            n_checks++;
            if (wr_addr[i] !== ea[i] || wr_data[i] !== ed[i] || wr_cyc[i] != ec[i]) begin
                n_errors++;
                $display("FAIL stall_write%0d: got addr=%0d data=%h cyc=%0d expected addr=%0d data=%h cyc=%0d",
                         i, wr_addr[i], wr_data[i], wr_cyc[i], ea[i], ed[i], ec[i]);
            end
        end
        n_checks++;
        if (n_bad_pop != 0 || n_pop != 4 || n_cen != 4 || done_cyc != 8) begin
            n_errors++;
            $display("FAIL stall_ctrl: got bad_pops=%0d pops=%0d cen_cycles=%0d done_cyc=%0d expected 0 4 4 8",
                     n_bad_pop, n_pop, n_cen, done_cyc);
        end
    endtask

    task automatic test_boundaries();
        // len = 0 with data waiting in the FIFO
        push(pack(3, 3, 3, 3));
        clear_log();
        start_xfer(0, 77, 1'b0, 1'b0);
        run_until_done("len0");
        n_checks++;
        if (done_cyc != 1 || n_cen != 0 || n_pop != 0 || busy_cnt != 0) begin
            n_errors++;
            $display("FAIL len0: got done_cyc=%0d cen_cycles=%0d pops=%0d busy=%0d expected 1 0 0 0",
                     done_cyc, n_cen, n_pop, busy_cnt);
        end
        // Address wrap at the top of the SRAM
        push(pack(4, 4, 4, 4));
        clear_log();
        start_xfer(2, 2047, 1'b0, 1'b0);
        run_until_done("wrap");
        n_checks++;
        if (wr_addr.size() != 2 || wr_addr[0] !== 11'd2047 || wr_addr[1] !== 11'd0 ||
            wr_data[0] !== pack(3, 3, 3, 3) || wr_data[1] !== pack(4, 4, 4, 4)) begin
            n_errors++;
            $display("FAIL addr_wrap: got n=%0d addr0=%0d addr1=%0d expected 2 2047 0",
                     wr_addr.size(), wr_addr[0], wr_addr[1]);
        end
        // Second start mid-transfer is ignored
        push(pack(51, 0, 0, 0));
        push(pack(52, 0, 0, 0));
        push(pack(53, 0, 0, 0));
        clear_log();
        start_xfer(3, 100, 1'b0, 1'b0);
        start = 1'b1; len = 12'd1; base_addr = 11'd500; acc_en = 1'b1;
        cycle();
        start = 1'b0;
        run_until_done("restart");
        repeat (3) cycle();
        n_checks++;
        if (wr_addr.size() != 3 || wr_addr[0] !== 11'd100 || wr_addr[2] !== 11'd102 ||
            wr_data[2] !== pack(53, 0, 0, 0) || done_cyc != 4) begin
            n_errors++;
            $display("FAIL restart_ignored: got n=%0d addr0=%0d addr2=%0d done_cyc=%0d expected 3 100 102 4",
                     wr_addr.size(), wr_addr[0], wr_addr[2], done_cyc);
        end
        n_checks++;
        if (done_cnt != 1 || busy_cnt != 3 || n_cen != 3 || n_pop != 3) begin
            n_errors++;
            $display("FAIL restart_quiet: got dones=%0d busy=%0d cen_cycles=%0d pops=%0d expected 1 3 3 3",
                     done_cnt, busy_cnt, n_cen, n_pop);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) push(pack(60 + i, 0, -(60 + i), 1));
        clear_log();
        start_xfer(4, 20, 1'b1, 1'b0);
        cycle();                 // cycle 1: FETCH, read issued
        reset = 1'b1;
        cycle();                 // cycle 2: ADD, reset taken at its closing edge
        reset = 1'b0;
        n_checks++;
        if (wr_cyc.size() != 1 || wr_cyc[0] != 2 || n_pop != 1) begin
            n_errors++;
            $display("FAIL rstmid_add: got writes=%0d cyc=%0d pops=%0d expected 1 2 1",
                     wr_cyc.size(), wr_cyc[0], n_pop);
        end
        @(negedge clk);
        n_checks++;
        if ({rd_ofifo, mem_cen, mem_wen, mem_addr, mem_din, busy, done} !==
            {1'b0, 1'b1, 1'b1, 11'd0, 64'd0, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL rstmid_idle: got rd=%b cen=%b wen=%b addr=%0d din=%h busy=%b done=%b expected 0 1 1 0 0 0 0",
                     rd_ofifo, mem_cen, mem_wen, mem_addr, mem_din, busy, done);
        end
        @(posedge clk);
        #1;
        repeat (4) cycle();
        n_checks++;
        if (n_pop != 1 || wr_cyc.size() != 1 || rd_cyc.size() != 1 || busy_cnt != 2 || done_cnt != 0) begin
            n_errors++;
            $display("FAIL rstmid_quiet: got pops=%0d writes=%0d reads=%0d busy=%0d dones=%0d expected 1 1 1 2 0",
                     n_pop, wr_cyc.size(), rd_cyc.size(), busy_cnt, done_cnt);
        end
        clear_log();
        start_xfer(2, 30, 1'b0, 1'b0);
        run_until_done("rstmid_new");
        n_checks++;
        if (wr_addr.size() != 2 || wr_addr[0] !== 11'd30 || wr_data[0] !== pack(61, 0, -61, 1) ||
            wr_addr[1] !== 11'd31 || wr_data[1] !== pack(62, 0, -62, 1) || done_cyc != 3) begin
            n_errors++;
            $display("FAIL rstmid_new: got n=%0d addr0=%0d data0=%h addr1=%0d done_cyc=%0d expected 2 30 %h 31 3",
                     wr_addr.size(), wr_addr[0], wr_data[0], wr_addr[1], done_cyc, pack(61, 0, -61, 1));
        end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        start     = 1'b0;
        len       = '0;
        base_addr = '0;
        acc_en    = 1'b0;
        relu_en   = 1'b0;
        mem_dout  = '0;
        fifo_wr   = 0;
        fifo_rd   = 0;
        vgate     = 1'b1;
        for (int i = 0; i < 2048; i++) sram[i] = '0;
        for (int i = 0; i < 64; i++) fifo[i] = '0;
        drive_fifo();
        clear_log();
        @(posedge clk);
        #1;

        test_reset();
        test_overwrite();
        test_accumulate();
        test_relu_wrap();
        test_stall();
        test_boundaries();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ofifo_psum_drain.md
Name: ofifo_psum_drain

Overview:
- Consumer-side controller for the core's output FIFO (OFIFO).
- After the core's execute phase, it pops partial-sum vectors from the OFIFO and writes them to psum SRAM at consecutive addresses.
- Per transfer, it either overwrites the SRAM contents or accumulates into them, with optional ReLU on the written value.
- It is the reader for the OFIFO that the array fills, and the writer of the psum memory the core's acc/relu path uses.

Parameters:
- col, 4, number of psum lanes per vector.
- psum_bw, 16, bits per lane (signed two's complement).
- addr_bw, 11, psum SRAM address width (2048 entries).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse that launches a transfer; sampled only in IDLE.
- len  in  addr_bw+1  number of vectors to drain; sampled on start.
- base_addr  in  addr_bw  first SRAM address; sampled on start.
- acc_en  in  1  1 = read-add-write, 0 = overwrite; sampled on start.
- relu_en  in  1  1 = clamp negative lanes to 0 before write; sampled on start.
- o_valid  in  1  OFIFO non-empty.
- ofifo_dout  in  col*psum_bw  OFIFO head vector (show-ahead, valid while o_valid); lane i = bits [i*psum_bw +: psum_bw].
- rd_ofifo  out  1  pop strobe; the head is consumed on the clk edge where rd_ofifo=1.
- mem_cen  out  1  SRAM chip enable, active-low.
- mem_wen  out  1  SRAM write enable, active-low (1 = read).
- mem_addr  out  addr_bw  SRAM address.
- mem_din  out  col*psum_bw  SRAM write data.
- mem_dout  in  col*psum_bw  SRAM read data, valid the cycle after a read is issued.
- busy  out  1  high from the cycle after an accepted start until the cycle done pulses.
- done  out  1  one-cycle completion pulse.

Behaviour:
- States: IDLE, FETCH, ADD, FIN.
- Reset (in any state, including mid-transfer) forces IDLE, clears the counter and latched config, and does not pop the OFIFO.
- Output values in reset and in IDLE:
  - rd_ofifo=0, mem_cen=1, mem_wen=1, mem_addr=0, mem_din=0.
  - busy=0, done=0.
- All memory and pop outputs are combinational from state, registers and o_valid.
- IDLE:
  - start=1 latches the config, sets addr=base_addr and cnt=0.
  - Next state is FETCH, or FIN if len=0. With len=0 there is no SRAM access and no pop.
- FETCH, acc_en=0, o_valid=1:
  - rd_ofifo=1, mem_cen=0, mem_wen=0, mem_addr=addr, mem_din=f(ofifo_dout).
  - addr++, cnt++. If cnt+1==len go to FIN, else stay in FETCH.
  - Throughput is 1 vector per cycle.
- FETCH, acc_en=1, o_valid=1:
  - rd_ofifo=1, mem_cen=0, mem_wen=1 (read issued), mem_addr=addr.
  - The head vector is captured into hold_reg. Go to ADD.
- FETCH, o_valid=0: stall with all strobes inactive. The stall may last indefinitely.
- ADD (acc_en=1 only):
  - mem_cen=0, mem_wen=0, mem_addr=addr, mem_din=f(mem_dout + hold_reg), added lane-wise.
  - rd_ofifo=0 regardless of o_valid.
  - addr++, cnt++. If cnt+1==len go to FIN, else go to FETCH.
  - Throughput is 1 vector per 2 cycles.
- FIN: done=1 for this one cycle, busy=0, then IDLE.
- busy is 1 in FETCH and ADD.
- Arithmetic:
  - The lane-wise sum wraps modulo 2^psum_bw, with no saturation.
  - f(x) applies ReLU per lane (lane MSB=1 gives 0) when relu_en=1, else identity.
  - ReLU is applied after the add.
- Address wraps modulo 2^addr_bw (base 2047 + 1 gives 0).
- start while not in IDLE is ignored; changes on the config inputs mid-transfer are ignored.
- rd_ofifo is never asserted while o_valid=0, so the block never pops an empty FIFO.
- The OFIFO is never popped more than len times per transfer.

Test Plan:
1. Overwrite drain.
   - Stimulus: reset; start len=3, base=5, acc_en=0, relu_en=0; OFIFO holds vectors V0..V2 with lane values {1,2,3,4},{-1,0,7,8},{9,9,9,9}, o_valid=1.
   - Required: writes on three consecutive cycles to addr 5,6,7 with unmodified data; 3 pops; done one cycle after the last write; busy=0 afterwards.
2. Accumulate.
   - Stimulus: SRAM addr 0 lanes = {10,-20,30,-40}; start len=1, base=0, acc_en=1, relu_en=0; head = {1,1,1,1}.
   - Required: read of addr 0, then next cycle a write of {11,-19,31,-39}; exactly 1 pop; total 2 busy cycles.
3. ReLU plus wrap.
   - Stimulus: acc_en=1, relu_en=1; stored {32767,-5,3,0}, head {1,2,-10,-1}.
   - Required: write {0,0,0,0}; 32767+1 wraps to -32768 and is clamped to 0.
4. Stall and empty FIFO.
   - Stimulus: len=4, acc_en=0; o_valid toggles 1,0,0,1,1,0,1.
   - Required: rd_ofifo and writes occur only in o_valid=1 cycles; addresses stay consecutive; done after the 4th write.
5. Boundaries.
   - len=0: done pulses the cycle after start, with mem_cen=1 and rd_ofifo=0 throughout.
   - base=2047, len=2: addresses are 2047 then 0.
   - A second start pulse mid-transfer is ignored.
6. Reset mid-transfer.
   - Stimulus: assert reset in an ADD cycle of a len=4 acc transfer.
   - Required: next cycle all outputs are at IDLE values with no further pops or writes; a new start afterwards completes normally.
